// File: rtl/scoreboard_defs.sv
// Shared definitions for the scoreboard button front end: per-channel FSM
// state encodings and default timing constants (1 cycle = 1 ms).
package scoreboard_defs;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESSED   = 2'd1;
  localparam logic [1:0] ST_LONG_HELD = 2'd2;

  localparam int DEF_DEBOUNCE_MS = 10;
  localparam int DEF_LONG_MS     = 1000;
  localparam int DEF_REPEAT_MS   = 250;

endpackage

// File: rtl/button_channel.sv
// One pushbutton: 2-FF synchroniser, counter debounce and short/long press FSM.
// Auto-repeat in LONG_HELD is built only when AUTO_REPEAT_EN is defined.
module button_channel
  import scoreboard_defs::*;
#(
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int LONG_MS     = DEF_LONG_MS,
  parameter int REPEAT_MS   = DEF_REPEAT_MS
) (
  input  logic clk_1khz_i,
  input  logic rst_i,
  input  logic button_i,
  output logic short_press_o,
  output logic long_press_o,
  output logic pressed_o
);

  localparam int DB_W   = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_W = $clog2(LONG_MS + 1);

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_MS - 1);
  // Long fires when the incremented hold count would equal LONG_MS-1.
  localparam logic [HOLD_W-1:0] LONG_PRE = HOLD_W'(LONG_MS - 2);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_MS);

  if (DEBOUNCE_MS < 1 || LONG_MS <= DEBOUNCE_MS || REPEAT_MS < 1) begin : g_param_check
    $error("button_channel: need DEBOUNCE_MS >= 1, LONG_MS > DEBOUNCE_MS, REPEAT_MS >= 1");
  end

  logic [1:0]        sync_reg;
  logic [DB_W-1:0]   db_cnt_reg;
  logic              level_reg;
  logic [1:0]        state_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic              short_reg;
  logic              long_reg;

  always_ff @(posedge clk_1khz_i) begin
    if (rst_i) begin
      sync_reg   <= 2'b00;
      db_cnt_reg <= '0;
      level_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], button_i};
      if (sync_reg[1] == level_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_LAST) begin
        level_reg  <= ~level_reg;
        db_cnt_reg <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_MS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_MS - 1);
  logic [REP_W-1:0] rep_reg;
`endif

  always_ff @(posedge clk_1khz_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      hold_reg  <= '0;
      short_reg <= 1'b0;
      long_reg  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_reg   <= '0;
`endif
    end else begin
      short_reg <= 1'b0;
      long_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (level_reg) begin
            state_reg <= ST_PRESSED;
            hold_reg  <= '0;
          end
        end
        ST_PRESSED: begin
          // Threshold is checked before release so a coincident fall is long-only.
          if (hold_reg == LONG_PRE) begin
            long_reg  <= 1'b1;
            state_reg <= ST_LONG_HELD;
            hold_reg  <= hold_reg + 1'b1;
`ifdef AUTO_REPEAT_EN
            rep_reg   <= '0;
`endif
          end else if (!level_reg) begin
            short_reg <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            hold_reg <= hold_reg + 1'b1;
          end
        end
        ST_LONG_HELD: begin
          if (!level_reg) begin
            state_reg <= ST_IDLE;
          end else begin
            if (hold_reg != HOLD_MAX) begin
              hold_reg <= hold_reg + 1'b1;
            end
`ifdef AUTO_REPEAT_EN
            if (rep_reg == REP_LAST) begin
              long_reg <= 1'b1;
              rep_reg  <= '0;
            end else begin
              rep_reg <= rep_reg + 1'b1;
            end
`endif
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign short_press_o = short_reg;
  assign long_press_o  = long_reg;
  assign pressed_o     = level_reg;

endmodule

// File: rtl/multi_button_processor.sv
// N_CH independent debounced pushbuttons with short/long press event pulses.
// Define AUTO_REPEAT_EN to make long_press_o repeat every REPEAT_MS while held.
module multi_button_processor
  import scoreboard_defs::*;
#(
  parameter int N_CH        = 2,
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int LONG_MS     = DEF_LONG_MS,
  parameter int REPEAT_MS   = DEF_REPEAT_MS
) (
  input  logic            clk_1khz_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] buttons_i,
  output logic [N_CH-1:0] short_press_o,
  output logic [N_CH-1:0] long_press_o,
  output logic [N_CH-1:0] pressed_o
);

  if (N_CH < 1 || N_CH > 8) begin : g_param_check
    $error("multi_button_processor: N_CH must be 1..8");
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    button_channel #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS),
      .REPEAT_MS   (REPEAT_MS)
    ) u_ch (
      .clk_1khz_i    (clk_1khz_i),
      .rst_i         (rst_i),
      .button_i      (buttons_i[gi]),
      .short_press_o (short_press_o[gi]),
      .long_press_o  (long_press_o[gi]),
      .pressed_o     (pressed_o[gi])
    );
  end

endmodule

// File: tb/tb_multi_button_processor.sv
// Directed bench for multi_button_processor with default timing (10/1000/250 ms).
module tb_multi_button_processor;

  localparam int N_CH = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] buttons = '0;
  logic [N_CH-1:0] short_press;
  logic [N_CH-1:0] long_press;
  logic [N_CH-1:0] pressed;

  multi_button_processor #(
    .N_CH        (N_CH),
    .DEBOUNCE_MS (10),
    .LONG_MS     (1000),
    .REPEAT_MS   (250)
  ) dut (
    .clk_1khz_i    (clk),
    .rst_i         (rst),
    .buttons_i     (buttons),
    .short_press_o (short_press),
    .long_press_o  (long_press),
    .pressed_o     (pressed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Event monitor sampled on the falling edge.
  int sp_cnt [N_CH];
  int lp_cnt [N_CH];
  int rise_cnt [N_CH];
  int sp_last [N_CH];
  int lp_last [N_CH];
  int rise_last [N_CH];
  logic [N_CH-1:0] prev_pressed = '0;

  always @(negedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (short_press[i] === 1'b1) begin sp_cnt[i]++; sp_last[i] = cyc; end
      if (long_press[i] === 1'b1) begin lp_cnt[i]++; lp_last[i] = cyc; end
      if (pressed[i] === 1'b1 && prev_pressed[i] === 1'b0) begin
        rise_cnt[i]++; rise_last[i] = cyc;
      end
    end
    prev_pressed = pressed;
  end

  int errors = 0;
  int checks = 0;

`ifdef AUTO_REPEAT_EN
  localparam int LONG_PULSES_1600 = 3;
  localparam int LAST_LONG_OFS    = 1500;
`else
  localparam int LONG_PULSES_1600 = 1;
  localparam int LAST_LONG_OFS    = 1000;
`endif

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int s0, l0;
    rst = 1'b1;
    buttons = '0;
    tick(2);
    rst = 1'b0;
    s0 = sp_cnt[0] + sp_cnt[1];
    l0 = lp_cnt[0] + lp_cnt[1];
    tick(50);
    checks++;
    if (pressed !== 2'b00) begin errors++; $display("FAIL reset_pressed: got %b expected 00", pressed); end
    checks++;
    if (short_press !== 2'b00) begin errors++; $display("FAIL reset_short: got %b expected 00", short_press); end
    checks++;
    if (long_press !== 2'b00) begin errors++; $display("FAIL reset_long: got %b expected 00", long_press); end
    checks++;
    if ((sp_cnt[0] + sp_cnt[1] - s0) !== 0 || (lp_cnt[0] + lp_cnt[1] - l0) !== 0) begin
      errors++; $display("FAIL reset_idle_pulses: got %0d short %0d long expected 0 0",
                         sp_cnt[0] + sp_cnt[1] - s0, lp_cnt[0] + lp_cnt[1] - l0);
    end
    $display("reset: pressed=%b short=%b long=%b", pressed, short_press, long_press);
  endtask

  task automatic test_short_bounce();
    int s0, l0, p, r;
    s0 = sp_cnt[0]; l0 = lp_cnt[0];
    buttons[0] = 1'b1; tick(1);
    buttons[0] = 1'b0; tick(2);
    buttons[0] = 1'b1; p = cyc; tick(25);
    checks++;
    if (pressed[0] !== 1'b1) begin errors++; $display("FAIL short_pressed_hi: got %b expected 1", pressed[0]); end
    checks++;
    if (rise_last[0] - p !== 12) begin errors++; $display("FAIL short_rise_lat: got %0d expected 12", rise_last[0] - p); end
    buttons[0] = 1'b0; tick(2);
    buttons[0] = 1'b1; tick(1);
    buttons[0] = 1'b0; r = cyc; tick(40);
    checks++;
    if (sp_cnt[0] - s0 !== 1) begin errors++; $display("FAIL short_count: got %0d expected 1", sp_cnt[0] - s0); end
    checks++;
    if (sp_last[0] - r !== 13) begin errors++; $display("FAIL short_lat: got %0d expected 13", sp_last[0] - r); end
    checks++;
    if (lp_cnt[0] - l0 !== 0) begin errors++; $display("FAIL short_no_long: got %0d expected 0", lp_cnt[0] - l0); end
    checks++;
    if (pressed[0] !== 1'b0) begin errors++; $display("FAIL short_pressed_lo: got %b expected 0", pressed[0]); end
    $display("short_bounce: short=%0d long=%0d latency=%0d", sp_cnt[0] - s0, lp_cnt[0] - l0, sp_last[0] - r);
  endtask

  task automatic test_long();
    int s0, l0, p;
    s0 = sp_cnt[0]; l0 = lp_cnt[0];
    buttons[0] = 1'b1; p = cyc; tick(1600);
    checks++;
    if (lp_cnt[0] - l0 !== LONG_PULSES_1600) begin
      errors++; $display("FAIL long_count: got %0d expected %0d", lp_cnt[0] - l0, LONG_PULSES_1600);
    end
    checks++;
    if (lp_last[0] - rise_last[0] !== LAST_LONG_OFS) begin
      errors++; $display("FAIL long_timing: got %0d expected %0d", lp_last[0] - rise_last[0], LAST_LONG_OFS);
    end
    checks++;
    if (rise_last[0] - p !== 12) begin errors++; $display("FAIL long_rise_lat: got %0d expected 12", rise_last[0] - p); end
    buttons[0] = 1'b0; tick(40);
    checks++;
    if (sp_cnt[0] - s0 !== 0) begin errors++; $display("FAIL long_no_short: got %0d expected 0", sp_cnt[0] - s0); end
    checks++;
    if (lp_cnt[0] - l0 !== LONG_PULSES_1600) begin
      errors++; $display("FAIL long_after_release: got %0d expected %0d", lp_cnt[0] - l0, LONG_PULSES_1600);
    end
    $display("long: long=%0d short=%0d last_ofs=%0d", lp_cnt[0] - l0, sp_cnt[0] - s0, lp_last[0] - rise_last[0]);
  endtask

  task automatic test_overlap();
    int s0, l0, s1, l1, p1;
    s0 = sp_cnt[0]; l0 = lp_cnt[0]; s1 = sp_cnt[1]; l1 = lp_cnt[1];
    buttons[1] = 1'b1; p1 = cyc; tick(5);
    buttons[0] = 1'b1; tick(25);
    buttons[0] = 1'b0; tick(1170);
    buttons[1] = 1'b0; tick(40);
    checks++;
    if (sp_cnt[0] - s0 !== 1) begin errors++; $display("FAIL overlap_short0: got %0d expected 1", sp_cnt[0] - s0); end
    checks++;
    if (lp_cnt[0] - l0 !== 0) begin errors++; $display("FAIL overlap_long0: got %0d expected 0", lp_cnt[0] - l0); end
    checks++;
    if (sp_cnt[1] - s1 !== 0) begin errors++; $display("FAIL overlap_short1: got %0d expected 0", sp_cnt[1] - s1); end
    checks++;
    if (lp_cnt[1] - l1 !== 1) begin errors++; $display("FAIL overlap_long1: got %0d expected 1", lp_cnt[1] - l1); end
    checks++;
    if (lp_last[1] - p1 !== 1012) begin errors++; $display("FAIL overlap_long1_time: got %0d expected 1012", lp_last[1] - p1); end
    $display("overlap: s0=%0d l0=%0d s1=%0d l1=%0d", sp_cnt[0] - s0, lp_cnt[0] - l0, sp_cnt[1] - s1, lp_cnt[1] - l1);
  endtask

  task automatic test_glitch();
    int r1, s1, l1;
    r1 = rise_cnt[1]; s1 = sp_cnt[1]; l1 = lp_cnt[1];
    buttons[1] = 1'b1; tick(9);
    buttons[1] = 1'b0; tick(40);
    checks++;
    if (rise_cnt[1] - r1 !== 0) begin errors++; $display("FAIL glitch9_rise: got %0d expected 0", rise_cnt[1] - r1); end
    checks++;
    if ((sp_cnt[1] - s1) + (lp_cnt[1] - l1) !== 0) begin
      errors++; $display("FAIL glitch9_pulses: got %0d expected 0", (sp_cnt[1] - s1) + (lp_cnt[1] - l1));
    end
    $display("glitch9: rises=%0d pulses=%0d", rise_cnt[1] - r1, (sp_cnt[1] - s1) + (lp_cnt[1] - l1));
    buttons[1] = 1'b1; tick(10);
    buttons[1] = 1'b0; tick(40);
    checks++;
    if (rise_cnt[1] - r1 !== 1) begin errors++; $display("FAIL glitch10_rise: got %0d expected 1", rise_cnt[1] - r1); end
    checks++;
    if (sp_cnt[1] - s1 !== 1) begin errors++; $display("FAIL glitch10_short: got %0d expected 1", sp_cnt[1] - s1); end
    $display("pulse10: rises=%0d short=%0d", rise_cnt[1] - r1, sp_cnt[1] - s1);
  endtask

  task automatic test_reset_midpress();
    int s0, l0, p;
    s0 = sp_cnt[0]; l0 = lp_cnt[0];
    buttons[0] = 1'b1; tick(512);
    rst = 1'b1; tick(1);
    checks++;
    if (pressed[0] !== 1'b0) begin errors++; $display("FAIL rstmid_pressed: got %b expected 0", pressed[0]); end
    buttons[0] = 1'b0; tick(3);
    rst = 1'b0; tick(40);
    checks++;
    if ((sp_cnt[0] - s0) !== 0 || (lp_cnt[0] - l0) !== 0) begin
      errors++; $display("FAIL rstmid_pulses: got %0d short %0d long expected 0 0", sp_cnt[0] - s0, lp_cnt[0] - l0);
    end
    // A fresh short press must behave normally, showing the FSM restarted in IDLE.
    buttons[0] = 1'b1; p = cyc; tick(25);
    buttons[0] = 1'b0; tick(40);
    checks++;
    if (sp_cnt[0] - s0 !== 1) begin errors++; $display("FAIL rstmid_next_short: got %0d expected 1", sp_cnt[0] - s0); end
    checks++;
    if (sp_last[0] - p !== 38) begin errors++; $display("FAIL rstmid_next_lat: got %0d expected 38", sp_last[0] - p); end
    $display("reset_midpress: short=%0d long=%0d", sp_cnt[0] - s0, lp_cnt[0] - l0);
  endtask

  initial begin
    test_reset();
    test_short_bounce();
    test_long();
    test_overlap();
    test_glitch();
    test_reset_midpress();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
